char_buffer_arbiter: RTL

Character-code buffer and write scheduler for the text overlay. The text-rectangle draw stage sends a `char_xy` read address every pixel clock; this block returns the character code from its internal 256-entry buffer on a fixed one-cycle read path. Two write requesters share the buffer through round-robin arbitration. A built-in clear engine fills the buffer with a blank code, and the write requesters are locked out while it runs.

---
 rtl/char_buffer_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/char_buffer_arbiter.sv
// ---------------------------------------------------------------------------
// char_buffer_arbiter
// Character-code buffer for the text overlay. A 256 x 7 RAM is read every
// pixel clock with one cycle of latency, written by two round-robin
// arbitrated requesters, and can be filled with CLEAR_CHAR by a built-in
// clear engine that locks the requesters out while it runs.
//
// Optional feature macro: CHARBUF_VBLANK_WRITE_EN
//   defined   : requester grants and clear writes only happen while vblnk_in=1
//   undefined : vblnk_in is ignored, writes proceed in any cycle
//
// Ports:
//   pclk, rst_n            clock, async active-low reset
//   char_xy  / char_code   read address {row,col} -> code one cycle later
//   vblnk_in               vertical blanking (macro builds only)
//   wr_valid/addr/data/ready 0,1   two write requesters (valid/ready)
//   clear_start            single-cycle clear request
//   busy, clear_done       clear engine running / completion pulse
// ---------------------------------------------------------------------------
module char_buffer_arbiter #(
  parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic [7:0] char_xy,
  output logic [6:0] char_code,
  input  logic       vblnk_in,
  input  logic       wr_valid0,
  input  logic       wr_valid1,
  input  logic [7:0] wr_addr0,
  input  logic [7:0] wr_addr1,
  input  logic [6:0] wr_data0,
  input  logic [6:0] wr_data1,
  output logic       wr_ready0,
  output logic       wr_ready1,
  input  logic       clear_start,
  output logic       busy,
  output logic       clear_done
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_ptr;
  logic       r_done;
  logic [6:0] r_code;
  logic [6:0] r_mem [0:255];

  logic       w_en;
  logic       w_arb_ok;
  logic       w_rdy0;
  logic       w_rdy1;
  logic       w_last_clear;
  logic       w_mem_we;
  logic [7:0] w_mem_addr;
  logic [6:0] w_mem_data;

`ifdef CHARBUF_VBLANK_WRITE_EN
  assign w_en = vblnk_in;
`else
  // vblnk_in has no function in this build
  logic w_unused_vblnk;
  assign w_unused_vblnk = vblnk_in;
  assign w_en = 1'b1;
`endif

  // Final clear write happens on this edge: last address and write enabled
  assign w_last_clear = (r_state == ST_CLEAR) && w_en && (r_cnt == 8'hFF);

  // Next-state logic for the IDLE/CLEAR engine
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (clear_start) begin
          w_state_nxt = ST_CLEAR;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (w_last_clear) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Round-robin grant: a lone requester always wins, on contention the
  // pointer decides. clear_start in the same cycle suppresses both grants.
  always_comb begin
    w_arb_ok = (r_state == ST_IDLE) && !clear_start && w_en;
    w_rdy0   = w_arb_ok && wr_valid0 && (!wr_valid1 || !r_ptr);
    w_rdy1   = w_arb_ok && wr_valid1 && (!wr_valid0 ||  r_ptr);
  end

  // Single RAM write port: clear engine first, then the granted requester
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = 8'h00;
    w_mem_data = 7'h00;
    if ((r_state == ST_CLEAR) && w_en) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_cnt;
      w_mem_data = CLEAR_CHAR;
    end else if (w_rdy0) begin
      w_mem_we   = 1'b1;
      w_mem_addr = wr_addr0;
      w_mem_data = wr_data0;
    end else if (w_rdy1) begin
      w_mem_we   = 1'b1;
      w_mem_addr = wr_addr1;
      w_mem_data = wr_data1;
    end else begin
      w_mem_we   = 1'b0;
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear address counter: loads 0 on start, steps on each enabled clear write
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 8'h00;
    end else if ((r_state == ST_IDLE) && clear_start) begin
      r_cnt <= 8'h00;
    end else if ((r_state == ST_CLEAR) && w_en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // Priority pointer moves away from the winner only after a contended transfer
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_rdy0 && wr_valid1) begin
      r_ptr <= 1'b1;
    end else if (w_rdy1 && wr_valid0) begin
      r_ptr <= 1'b0;
    end
  end

  // Completion pulse in the cycle after the last clear write
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_last_clear;
    end
  end

  // Character RAM write, intentionally not reset
  always_ff @(posedge pclk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Read register; non-blocking read gives old data on a same-edge write
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_code <= 7'h00;
    end else begin
      r_code <= r_mem[char_xy];
    end
  end

  assign char_code  = r_code;
  assign busy       = (r_state == ST_CLEAR);
  assign clear_done = r_done;
  assign wr_ready0  = w_rdy0;
  assign wr_ready1  = w_rdy1;

endmodule
